multicycle_proc: RTL and testbench
==================================

# multicycle_proc

Multi-cycle LEGv8 core: the next generation of the single-cycle processor. It executes the same base instruction subset through a fetch/decode/execute/memory/writeback state machine. Instruction and data memories sit outside the block behind req/ready handshakes, so the core tolerates variable-latency memories and stalls cleanly. The core contains its own 32x64 register file and ALU, and exposes writeback, retire-count and halt observability for system-level benches.

## Interface
- ADDR_W, 64, width of PC and memory addresses (upper bits zero-extended internally to 64 for ALU use)
- CNT_W, 32, width of retired-instruction counter
- CLK  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- startpc  input  ADDR_W  PC loaded while reset is high
- imem_req  output  1  instruction fetch request
- imem_addr  output  ADDR_W  fetch address (= currentpc)
- imem_ready  input  1  fetch completes on an edge where imem_req && imem_ready
- imem_rdata  input  32  instruction word, valid with imem_ready
- dmem_req  output  1  data access request
- dmem_we  output  1  1 = store, 0 = load
- dmem_addr  output  ADDR_W  effective address (ALU result, truncated)
- dmem_wdata  output  64  store data (Rt register value)
- dmem_ready  input  1  access completes on an edge where dmem_req && dmem_ready
- dmem_rdata  input  64  load data, valid with dmem_ready
- currentpc  output  ADDR_W  PC of the instruction in flight
- MemtoRegOut  output  64  value written to the register file this cycle
- wb_valid  output  1  register write occurs this cycle
- retired  output  CNT_W  instructions completed since reset, wraps modulo 2^CNT_W
- halted  output  1  core stopped on an unsupported opcode

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset forces FETCH.
- FETCH: imem_req=1, held stable until the handshake edge; the instruction is latched into IR; next state DECODE.
- DECODE: read Rn=IR[9:5]. Read the second operand from IR[20:16] for R-type and from IR[4:0] for STUR/CBZ. Latch A/B and the sign-extended immediate.
- EXEC, per opcode (IR[31:21]):
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: A op B, then WB.
  - LDUR 11111000010: A + sext(IR[20:12]), then MEM.
  - STUR 11111000000: same address calculation, then MEM.
  - MOVZ 110100101xx: zext(IR[20:5]) << (16*IR[22:21]), then WB.
  - CBZ 10110100xxx: if B==0 then PC += sext(IR[23:5])<<2, else PC += 4. Retire, then FETCH.
  - B 000101xxxxx: PC += sext(IR[25:0])<<2. Retire, then FETCH.
  - Any other opcode: HALT. PC is unchanged and the instruction is not retired.
- MEM: dmem_req=1, held stable until the handshake edge.
  - Store: retire, PC += 4, then FETCH.
  - Load: latch dmem_rdata, then WB.
- WB: write Rd=IR[4:0] with the result; wb_valid=1. A write to X31 is suppressed and wb_valid=0, but the instruction still retires. PC += 4, then FETCH.
- Register X31 always reads 0. All other registers reset to 0.
- Arithmetic is 64-bit modulo 2^64. PC arithmetic is modulo 2^ADDR_W.
- HALT: all requests are 0 and outputs hold. Only reset exits HALT.

## Timing
- All outputs are registered or decoded from registered state. No combinational path runs from imem_ready/dmem_ready to req.
- Reset values: currentpc=startpc, imem_req=1 on the first cycle after reset deasserts (state FETCH), dmem_req=0, dmem_we=0, wb_valid=0, MemtoRegOut=0, retired=0, halted=0.
- With zero-wait memory (ready=1), cycles per instruction are: R-type/MOVZ 4 (F,D,X,W), LDUR 5, STUR 4, CBZ/B 3. Each wait cycle adds 1.
- req, addr, we and wdata stay constant while req=1 and ready=0. req drops in the cycle after the handshake edge.
- retired increments on the last edge of each completed instruction. currentpc updates on the same edge.
- Reset mid-transaction abandons it: req is 0 on the cycle after the reset edge, no register or memory side effects occur, and retired clears.
- A ready asserted without a matching req is ignored.

## Test plan
- startpc=0x100, zero-wait memories, program MOVZ X1,#5; ADD X2,X1,X1 -> X2=10; wb_valid pulses with MemtoRegOut=5 then 10; retired=2 after 8 cycles.
- STUR X2,[X0,#8] then LDUR X3,[X0,#8] with dmem_ready delayed 3 cycles -> dmem_addr=8 and dmem_wdata=10 stable throughout the wait, X3=10, LDUR takes 8 cycles.
- CBZ X0,#+3 at 0x100 -> next fetch at 0x10C. CBZ X1 (X1=5) -> next fetch at 0x104. B #-1 -> imem_addr returns to the previous word.
- ADD X31,X1,X1 -> wb_valid=0, a later read of X31 returns 0, retired still increments.
- Opcode 0x000 fetched -> halted=1, imem_req=0 forever, currentpc frozen. Asserting reset -> halted=0 and fetch restarts at startpc.
- Reset asserted while imem_req=1 and imem_ready=0 -> req=0 on the next cycle, retired=0, the first post-reset fetch uses the new startpc.

Source files
------------

// File: rtl/multicycle_proc.sv
// multicycle_proc: multi-cycle LEGv8 core with handshaked instruction/data memories
module multicycle_proc #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] startpc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [63:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [63:0]       dmem_rdata,
  output logic [ADDR_W-1:0] currentpc,
  output logic [63:0]       MemtoRegOut,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retired,
  output logic              halted
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_d;
  logic [31:0] ir;
  logic [63:0] a, b, imm, res, alu, movz_val, ra, rb;
  logic [63:0] rf [32];
  logic [10:0] op;
  logic [4:0] rm_idx;
  logic is_add, is_sub, is_and, is_orr, is_ldur, is_stur, is_movz, is_cbz, is_b, is_r;
  logic retire, take;
  logic [ADDR_W-1:0] pc_next;
  assign op      = ir[31:21];
  assign is_add  = op == 11'b10001011000;
  assign is_sub  = op == 11'b11001011000;
  assign is_and  = op == 11'b10001010000;
  assign is_orr  = op == 11'b10101010000;
  assign is_ldur = op == 11'b11111000010;
  assign is_stur = op == 11'b11111000000;
  assign is_movz = op[10:2] == 9'b110100101;
  assign is_cbz  = op[10:3] == 8'b10110100;
  assign is_b    = op[10:5] == 6'b000101;
  assign is_r    = is_add | is_sub | is_and | is_orr;
  assign rm_idx  = is_r ? ir[20:16] : ir[4:0];
  assign ra      = ir[9:5] == 5'd31 ? 64'd0 : rf[ir[9:5]];
  assign rb      = rm_idx == 5'd31 ? 64'd0 : rf[rm_idx];
  assign movz_val = {48'd0, ir[20:5]} << {ir[22:21], 4'd0};
  assign alu = is_add ? a + b :
               is_sub ? a - b :
               is_and ? a & b :
               is_orr ? a | b :
               is_movz ? movz_val :
               (is_ldur | is_stur) ? a + imm : 64'd0;
  // Requests are gated by reset so an abandoned transaction drops req immediately.
  assign imem_req    = state == FETCH && !reset;
  assign imem_addr   = currentpc;
  assign dmem_req    = state == MEM && !reset;
  assign dmem_we     = dmem_req && is_stur;
  assign dmem_addr   = res[ADDR_W-1:0];
  assign dmem_wdata  = b;
  assign wb_valid    = state == WB && ir[4:0] != 5'd31 && !reset;
  assign MemtoRegOut = wb_valid ? res : 64'd0;
  assign halted      = state == HALT;
  assign take    = state == EXEC && (is_b || (is_cbz && b == 64'd0));
  assign retire  = (state == EXEC && (is_cbz || is_b)) || (dmem_req && dmem_ready && is_stur) || state == WB;
  assign pc_next = currentpc + (take ? imm[ADDR_W-1:0] : ADDR_W'(4));
  always_comb begin
    state_d = state;
    case (state)
      FETCH:  state_d = imem_ready ? DECODE : FETCH;
      DECODE: state_d = EXEC;
      EXEC:   state_d = (is_r || is_movz) ? WB : (is_ldur || is_stur) ? MEM : (is_cbz || is_b) ? FETCH : HALT;
      MEM:    state_d = !dmem_ready ? MEM : is_stur ? FETCH : WB;
      WB:     state_d = FETCH;
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= FETCH;
      currentpc <= startpc;
      retired   <= '0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      imm       <= '0;
      res       <= '0;
    end else begin
      state <= state_d;
      if (state == FETCH && imem_ready) ir <= imem_rdata;
      if (state == DECODE) begin
        a   <= ra;
        b   <= rb;
        imm <= is_cbz ? {{43{ir[23]}}, ir[23:5], 2'b00} :
               is_b   ? {{36{ir[25]}}, ir[25:0], 2'b00} : {{55{ir[20]}}, ir[20:12]};
      end
      if (state == EXEC) res <= alu;
      if (dmem_req && dmem_ready && !is_stur) res <= dmem_rdata;
      if (retire) begin
        currentpc <= pc_next;
        retired   <= retired + CNT_W'(1);
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_valid) begin
      rf[ir[4:0]] <= res;
    end
  end
endmodule

// File: tb/tb_multicycle_proc.sv
// tb_multicycle_proc: directed program run against the multi-cycle core with TB-side memories
module tb_multicycle_proc;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  logic        CLK = 0;
  logic        reset;
  logic [63:0] startpc;
  logic        imem_req, imem_ready;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [63:0] currentpc, MemtoRegOut;
  logic        wb_valid, halted;
  logic [31:0] retired;
  logic [31:0] imem [256];
  logic [63:0] dmem [16];
  logic [3:0]  dcnt = 0;
  logic [3:0]  dwait;
  int tests = 0, fails = 0;

  multicycle_proc dut (
    .CLK(CLK), .reset(reset), .startpc(startpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .currentpc(currentpc), .MemtoRegOut(MemtoRegOut), .wb_valid(wb_valid),
    .retired(retired), .halted(halted)
  );

  always #5 CLK = ~CLK;
  assign imem_rdata = imem[imem_addr[9:2]];
  assign dmem_rdata = dmem[dmem_addr[6:3]];
  assign dmem_ready = dmem_req && dcnt >= dwait;
  always @(posedge CLK) begin
    dcnt <= (dmem_req && !dmem_ready) ? dcnt + 4'd1 : 4'd0;
    if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[6:3]] <= dmem_wdata;
  end

  function automatic logic [31:0] rtype(input logic [10:0] op, input logic [4:0] rm, rn, rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] dtype(input logic [10:0] op, input logic [8:0] off, input logic [4:0] rn, rt);
    return {op, off, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] movz(input logic [1:0] hw, input logic [15:0] v, input logic [4:0] rd);
    return {9'b110100101, hw, v, rd};
  endfunction
  function automatic logic [31:0] cbz(input logic [18:0] off, input logic [4:0] rt);
    return {8'b10110100, off, rt};
  endfunction
  function automatic logic [31:0] bra(input logic [25:0] off);
    return {6'b000101, off};
  endfunction

  task automatic put(input logic [63:0] addr, input logic [31:0] w);
    imem[addr[9:2]] = w;
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // Starts in the fetch cycle of an instruction and ends in the fetch cycle of the next.
  task automatic inst(input string tag, input int cyc, input logic expv, input logic [63:0] expd,
                      input logic [63:0] npc);
    check({tag, "_req"}, {63'd0, imem_req}, 64'd1);
    tick(cyc - 1);
    check({tag, "_wbv"}, {63'd0, wb_valid}, {63'd0, expv});
    check({tag, "_wbd"}, MemtoRegOut, expv ? expd : 64'd0);
    tick(1);
    check({tag, "_pc"}, currentpc, npc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    put(64'h100, movz(2'd0, 16'd5, 5'd1));
    put(64'h104, rtype(OP_ADD, 5'd1, 5'd1, 5'd2));
    put(64'h108, dtype(OP_STUR, 9'd8, 5'd31, 5'd2));
    put(64'h10C, dtype(OP_LDUR, 9'd8, 5'd31, 5'd3));
    put(64'h110, rtype(OP_ADD, 5'd1, 5'd1, 5'd31));
    put(64'h114, rtype(OP_ADD, 5'd1, 5'd31, 5'd4));
    put(64'h118, rtype(OP_SUB, 5'd2, 5'd1, 5'd5));
    put(64'h11C, movz(2'd1, 16'hF0F0, 5'd6));
    put(64'h120, rtype(OP_AND, 5'd5, 5'd6, 5'd7));
    put(64'h124, rtype(OP_ORR, 5'd1, 5'd6, 5'd8));
    put(64'h128, cbz(19'd8, 5'd1));
    put(64'h12C, cbz(19'd2, 5'd31));
    put(64'h130, movz(2'd0, 16'h77, 5'd9));
    put(64'h134, movz(2'd0, 16'd3, 5'd10));
    put(64'h138, bra(26'd4));
    put(64'h13C, movz(2'd0, 16'h77, 5'd9));
    put(64'h140, movz(2'd0, 16'h77, 5'd9));
    put(64'h148, bra(26'h3FFFFFF));
    reset = 1; startpc = 64'h100; imem_ready = 1; dwait = 4'd3;
    tick(2);
    reset = 0;
    #1;
    check("rst_pc", currentpc, 64'h100);
    check("rst_ireq", {63'd0, imem_req}, 64'd1);
    check("rst_dreq", {63'd0, dmem_req}, 64'd0);
    check("rst_we", {63'd0, dmem_we}, 64'd0);
    check("rst_wbv", {63'd0, wb_valid}, 64'd0);
    check("rst_m2r", MemtoRegOut, 64'd0);
    check("rst_ret", {32'd0, retired}, 64'd0);
    check("rst_halt", {63'd0, halted}, 64'd0);
    inst("movz5", 4, 1'b1, 64'd5, 64'h104);
    inst("add_x2", 4, 1'b1, 64'd10, 64'h108);
    check("ret_after8", {32'd0, retired}, 64'd2);
    tick(3);
    check("stur_req_w0", {62'd0, dmem_req, dmem_we}, 64'd3);
    check("stur_addr_w0", dmem_addr, 64'd8);
    check("stur_data_w0", dmem_wdata, 64'd10);
    tick(3);
    check("stur_req_w3", {62'd0, dmem_req, dmem_we}, 64'd3);
    check("stur_addr_w3", dmem_addr, 64'd8);
    check("stur_data_w3", dmem_wdata, 64'd10);
    tick(1);
    check("stur_req_drop", {63'd0, dmem_req}, 64'd0);
    check("stur_pc", currentpc, 64'h10C);
    tick(3);
    check("ldur_req", {62'd0, dmem_req, dmem_we}, 64'd2);
    check("ldur_addr", dmem_addr, 64'd8);
    tick(4);
    check("ldur_wbv", {63'd0, wb_valid}, 64'd1);
    check("ldur_wbd", MemtoRegOut, 64'd10);
    tick(1);
    check("ldur_pc", currentpc, 64'h110);
    check("ret_after_ld", {32'd0, retired}, 64'd4);
    inst("add_x31", 4, 1'b0, 64'd0, 64'h114);
    check("ret_x31", {32'd0, retired}, 64'd5);
    inst("read_x31", 4, 1'b1, 64'd5, 64'h118);
    inst("sub", 4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'h11C);
    inst("movz_lsl16", 4, 1'b1, 64'hF0F0_0000, 64'h120);
    inst("and", 4, 1'b1, 64'hF0F0_0000, 64'h124);
    inst("orr", 4, 1'b1, 64'hF0F0_0005, 64'h128);
    inst("cbz_nt", 3, 1'b0, 64'd0, 64'h12C);
    inst("cbz_t", 3, 1'b0, 64'd0, 64'h134);
    inst("movz3", 4, 1'b1, 64'd3, 64'h138);
    inst("b_fwd", 3, 1'b0, 64'd0, 64'h148);
    inst("b_back", 3, 1'b0, 64'd0, 64'h144);
    check("ret_pre_halt", {32'd0, retired}, 64'd15);
    tick(3);
    check("halt_flag", {63'd0, halted}, 64'd1);
    check("halt_ireq", {63'd0, imem_req}, 64'd0);
    tick(5);
    check("halt_hold", {63'd0, halted}, 64'd1);
    check("halt_ireq2", {62'd0, imem_req, dmem_req}, 64'd0);
    check("halt_pc", currentpc, 64'h144);
    check("halt_ret", {32'd0, retired}, 64'd15);
    put(64'h100, cbz(19'd3, 5'd31));
    put(64'h10C, rtype(OP_ADD, 5'd1, 5'd1, 5'd12));
    reset = 1;
    tick(1);
    check("unhalt", {63'd0, halted}, 64'd0);
    reset = 0;
    #1;
    check("restart_addr", imem_addr, 64'h100);
    inst("cbz_x0_3", 3, 1'b0, 64'd0, 64'h10C);
    inst("rf_cleared", 4, 1'b1, 64'd0, 64'h110);
    check("ret_2", {32'd0, retired}, 64'd2);
    imem_ready = 0;
    tick(3);
    check("stall_req", {63'd0, imem_req}, 64'd1);
    check("stall_addr", imem_addr, 64'h110);
    reset = 1; startpc = 64'h200;
    put(64'h200, movz(2'd2, 16'd7, 5'd1));
    tick(1);
    check("abort_req", {63'd0, imem_req}, 64'd0);
    check("abort_ret", {32'd0, retired}, 64'd0);
    check("abort_pc", currentpc, 64'h200);
    reset = 0; imem_ready = 1;
    #1;
    check("new_start", imem_addr, 64'h200);
    inst("movz_lsl32", 4, 1'b1, 64'h7_0000_0000, 64'h204);
    check("ret_new", {32'd0, retired}, 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
